// File: rtl/edge_offset_solver.sv
// Edge offset solver: a = (2*SM - 5*(A+B)) / (2*(A-B)) in signed fixed point.
// Fixed-latency restoring divider behind valid/ready handshakes.
module edge_offset_solver #(
  parameter int SM_W   = 11,
  parameter int AB_W   = 10,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SM_W-1:0]         sm,
  input  logic [AB_W-1:0]         a_in,
  input  logic [AB_W-1:0]         b_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] result,
  output logic                    div_by_zero
);

  localparam int NUM_W = AB_W + 5;
  localparam int ITER  = NUM_W + FRAC_W;
  localparam int DW    = AB_W + 2;
  localparam int CW    = $clog2(ITER);
  localparam int SW    = (ITER > OUT_W ? ITER : OUT_W) + 1;

  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic signed [SW-1:0] MAXV =
    SW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {
    IDLE, PREP, DIV, FIX, DONE
  } state_t;

  state_t state, state_n;

  logic [SM_W-1:0] sm_q;
  logic [AB_W-1:0] a_q, b_q;
  logic [ITER-1:0] quo;
  logic [DW-1:0]   rem, dvs;
  logic [CW-1:0]   cnt;
  logic            neg, n_neg, n_zero, dz_q;

  logic [NUM_W-1:0] sum_c, n_c, n_abs;
  logic [DW-1:0]    d_c, d_abs, rem_n;
  logic [DW:0]      shf;
  logic             take;
  logic signed [SW-1:0]    qe, sq;
  logic signed [OUT_W-1:0] res_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = PREP;
      PREP:    state_n = DIV;
      DIV:     if (cnt == LAST) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand arithmetic is done modulo 2^width; the widths rule out overflow.
  always_comb begin
    sum_c = NUM_W'(a_q) + NUM_W'(b_q);
    n_c   = (NUM_W'(sm_q) << 1) - ((sum_c << 2) + sum_c);
    d_c   = (DW'(a_q) - DW'(b_q)) << 1;
    n_abs = n_c[NUM_W-1] ? -n_c : n_c;
    d_abs = d_c[DW-1] ? -d_c : d_c;
  end

  always_comb begin
    shf   = {rem, quo[ITER-1]};
    take  = shf >= (DW+1)'(dvs);
    rem_n = take ? DW'(shf - (DW+1)'(dvs)) : shf[DW-1:0];
  end

  always_comb begin
    qe = SW'(quo);
    sq = neg ? -qe : qe;
    if (dz_q) begin
      if (n_zero)     res_c = '0;
      else if (n_neg) res_c = MINV[OUT_W-1:0];
      else            res_c = MAXV[OUT_W-1:0];
    end else if (sq > MAXV) begin
      res_c = MAXV[OUT_W-1:0];
    end else if (sq < MINV) begin
      res_c = MINV[OUT_W-1:0];
    end else begin
      res_c = sq[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      div_by_zero <= 1'b0;
      sm_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      n_neg       <= 1'b0;
      n_zero      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sm_q <= sm;
          a_q  <= a_in;
          b_q  <= b_in;
        end
        PREP: begin
          quo    <= {n_abs, FRAC_W'(0)};
          dvs    <= d_abs;
          rem    <= '0;
          cnt    <= '0;
          neg    <= n_c[NUM_W-1] ^ d_c[DW-1];
          n_neg  <= n_c[NUM_W-1];
          n_zero <= (n_c == '0);
          dz_q   <= (d_c == '0);
        end
        DIV: begin
          quo <= {quo[ITER-2:0], take};
          rem <= rem_n;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          result      <= res_c;
          div_by_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/edge_offset_solver.md
EDGE_OFFSET_SOLVER -- requirements
Module: edge_offset_solver

Interface
REQ-001 SHALL provide parameter SM_W, default 11, bit width of unsigned input sm; constraint SM_W <= AB_W+2.
REQ-002 SHALL provide parameter AB_W, default 10, bit width of unsigned inputs a_in and b_in.
REQ-003 SHALL provide parameter FRAC_W, default 16, number of fractional bits in the result.
REQ-004 SHALL provide parameter OUT_W, default 32, bit width of signed result.
REQ-005 SHALL define local NUM_W = AB_W+5 (numerator width) and local ITER = NUM_W+FRAC_W (divider iterations; 31 at defaults).
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1: input handshake; transfer occurs when both are high on a rising edge.
REQ-009 SHALL have ports sm input SM_W, a_in input AB_W, b_in input AB_W: operands SM, A and B.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1: output handshake.
REQ-011 SHALL have port result output OUT_W: signed two's-complement a, scaled by 2^FRAC_W.
REQ-012 SHALL have port div_by_zero output 1: high with result when A == B.

Function
REQ-013 SHALL compute N = 2*SM - 5*(A+B) as signed NUM_W and D = 2*(A-B) as signed AB_W+2, with no overflow.
REQ-014 SHALL compute result = trunc_toward_zero(N*2^FRAC_W / D), saturated to the signed OUT_W range.
REQ-015 SHALL implement the FSM states IDLE, PREP, DIV, FIX and DONE.
- IDLE->PREP on accept.
- PREP->DIV after 1 cycle.
- DIV->FIX after exactly ITER cycles.
- FIX->DONE after 1 cycle.
- DONE->IDLE when out_ready is high.
REQ-016 SHALL register sm, a_in and b_in on accept; input changes after accept SHALL NOT affect the result.
REQ-017 SHALL, in PREP, form N and D, store |N| left-shifted by FRAC_W, store |D|, and store the sign N xor sign D.
REQ-018 SHALL, in DIV, run a restoring radix-2 unsigned division producing one quotient bit per cycle, MSB first.
REQ-019 SHALL, in FIX, apply the sign, saturate, and register result and div_by_zero.
REQ-020 SHALL assert in_ready only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-021 SHALL assert out_valid only in DONE; result and div_by_zero SHALL hold stable while out_valid is high and out_ready is low.
REQ-022 SHALL have a fixed latency: with the accept on edge T0, out_valid rises after edge T0+ITER+2 (33 at defaults), independent of the operands.
REQ-023 SHALL, when D == 0, still run the full latency and force result as follows, with div_by_zero=1:
- N>0: max positive.
- N<0: min negative.
- N==0: 0.
REQ-024 SHALL drive div_by_zero=0 for every D != 0.
REQ-025 SHALL allow the earliest next accept on the edge after the DONE->IDLE transition, giving a throughput of one result per ITER+4 cycles.

Reset
REQ-026 SHALL, while rst is high at a rising edge, set state=IDLE, out_valid=0, result=0 and div_by_zero=0, with in_ready=1 from the following cycle.
REQ-027 SHALL abandon any in-flight operation on reset in any state, with no out_valid for it afterwards.
REQ-028 SHALL, if rst and in_valid are high on the same edge, give reset priority: no accept occurs.

Verification
REQ-029 SHALL cover: SM=1000, A=100, B=50 -> N=1250, D=100, result=0x000C8000 (12.5), div_by_zero=0, out_valid 33 cycles after accept.
REQ-030 SHALL cover sign handling:
- SM=0, A=20, B=10 -> result=0xFFF88000 (-7.5).
- SM=0, A=10, B=20 -> result=0x00078000 (+7.5).
REQ-031 SHALL cover truncation:
- SM=8, A=3, B=0 -> N=1, D=6, result=0x00002AAA.
- SM=7, A=3, B=0 -> result=0xFFFFD556.
REQ-032 SHALL cover divide by zero:
- SM=0, A=B=30 -> result=0x80000000, div_by_zero=1, same latency.
- SM=500, A=B=10 -> result=0x7FFFFFFF, div_by_zero=1.
REQ-033 SHALL cover backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays high, result stable, in_ready=0; the op drains on out_ready=1 and the next op is accepted on the following edge.
REQ-034 SHALL cover reset mid-operation: assert rst at DIV cycle 12 -> out_valid never rises for that op; after reset, in_ready=1 and a fresh op (SM=1000, A=100, B=50) returns 0x000C8000.
